// File: rtl/wb_port_arb_if.sv
// wb_port_arb_if: requester writeback inputs and dual register-file write ports
interface wb_port_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [3:0]          req_valid;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                wen0;
  logic [ADDR_W-1:0]   waddr0;
  logic [DATA_W-1:0]   wdata0;
  logic                wen1;
  logic [ADDR_W-1:0]   waddr1;
  logic [DATA_W-1:0]   wdata1;
  logic [7:0]          conflict_cnt;
  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1, conflict_cnt
  );
  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1, conflict_cnt
  );
endinterface

// File: rtl/wb_port_arb.sv
// wb_port_arb: four one-entry writeback buffers arbitrated round-robin onto two register-file write ports
module wb_port_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  wb_port_arb_if.slave bus
);
  logic [3:0]        held;
  logic [ADDR_W-1:0] haddr [4];
  logic [DATA_W-1:0] hdata [4];
  logic [1:0]        rr_ptr, ga, gb, j, defer;
  logic              ga_v, gb_v;
  logic [3:0]        grant, cap;
  logic [8:0]        cnt_sum;
  assign bus.req_ready = ~held;
  assign cap = bus.req_valid & ~held;
  assign grant = (ga_v ? 4'(1) << ga : 4'd0) | (gb_v ? 4'(1) << gb : 4'd0);
  assign cnt_sum = {1'b0, bus.conflict_cnt} + 9'(defer);
  // port B is checked before A is claimed so the A entry never competes with itself
  always_comb begin
    ga_v = 1'b0;
    gb_v = 1'b0;
    ga = rr_ptr;
    gb = rr_ptr;
    j = rr_ptr;
    defer = '0;
    for (int k = 0; k < 4; k++) begin
      j = rr_ptr + 2'(k);
      if (held[j] && ga_v && !gb_v) begin
        if (haddr[j] == haddr[ga]) defer = defer + 2'd1;
        else begin
          gb_v = 1'b1;
          gb = j;
        end
      end
      if (held[j] && !ga_v) begin
        ga_v = 1'b1;
        ga = j;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (cap[i]) begin
        haddr[i] <= bus.req_addr[i*ADDR_W +: ADDR_W];
        hdata[i] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held <= '0;
      rr_ptr <= '0;
      bus.wen0 <= 1'b0;
      bus.wen1 <= 1'b0;
      bus.waddr0 <= '0;
      bus.waddr1 <= '0;
      bus.wdata0 <= '0;
      bus.wdata1 <= '0;
      bus.conflict_cnt <= '0;
    end else begin
      held <= (held & ~grant) | cap;
      bus.wen0 <= ga_v;
      bus.wen1 <= gb_v;
      if (ga_v) begin
        bus.waddr0 <= haddr[ga];
        bus.wdata0 <= hdata[ga];
        rr_ptr <= (gb_v ? gb : ga) + 2'd1;
      end
      if (gb_v) begin
        bus.waddr1 <= haddr[gb];
        bus.wdata1 <= hdata[gb];
      end
      bus.conflict_cnt <= cnt_sum > 9'd255 ? 8'd255 : cnt_sum[7:0];
    end
  end
endmodule

// File: tb/tb_wb_port_arb.sv
// tb_wb_port_arb: directed and randomized checks of wb_port_arb against a queue-based reference model
module tb_wb_port_arb;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  int lowc [4];
  bit fair = 0;
  wb_port_arb_if #(.DATA_W(16), .ADDR_W(3)) bus();
  wb_port_arb #(.DATA_W(16), .ADDR_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {bit v; logic [2:0] a; logic [15:0] d;} ent_t;
  ent_t m [4];
  int rr, cnt;
  bit e0, e1;
  logic [2:0] a0, a1;
  logic [15:0] d0, d1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [15:0] d);
    bus.req_addr[i*3 +: 3] = a;
    bus.req_data[i*16 +: 16] = d;
  endtask

  // reference: list the held requesters in round-robin order, grant the first, then the first with a different address
  task automatic model_edge();
    int order[$];
    int ga = -1, gb = -1, df = 0;
    bit capm [4];
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m[i].v = 0;
      rr = 0; cnt = 0; e0 = 0; e1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      return;
    end
    for (int i = 0; i < 4; i++) capm[i] = bus.req_valid[i] && !m[i].v;
    for (int k = 0; k < 4; k++) if (m[(rr + k) % 4].v) order.push_back((rr + k) % 4);
    if (order.size() > 0) ga = order[0];
    for (int n = 1; n < order.size(); n++)
      if (gb < 0) begin
        if (m[order[n]].a == m[ga].a) df++;
        else gb = order[n];
      end
    e0 = ga >= 0;
    e1 = gb >= 0;
    if (e0) begin a0 = m[ga].a; d0 = m[ga].d; m[ga].v = 0; rr = ((e1 ? gb : ga) + 1) % 4; end
    if (e1) begin a1 = m[gb].a; d1 = m[gb].d; m[gb].v = 0; end
    cnt = (cnt + df > 255) ? 255 : cnt + df;
    for (int i = 0; i < 4; i++)
      if (capm[i]) begin
        m[i].v = 1;
        m[i].a = bus.req_addr[i*3 +: 3];
        m[i].d = bus.req_data[i*16 +: 16];
      end
  endtask

  task automatic step();
    logic [3:0] rdy;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rdy[i] = !m[i].v;
    chk("wen0", 32'(bus.wen0), 32'(e0));
    chk("wen1", 32'(bus.wen1), 32'(e1));
    chk("waddr0", 32'(bus.waddr0), 32'(a0));
    chk("wdata0", 32'(bus.wdata0), 32'(d0));
    chk("waddr1", 32'(bus.waddr1), 32'(a1));
    chk("wdata1", 32'(bus.wdata1), 32'(d1));
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(cnt));
    chk("port_collision", 32'(bus.wen0 && bus.wen1 && bus.waddr0 == bus.waddr1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      lowc[i] = bus.req_ready[i] ? 0 : lowc[i] + 1;
      if (fair) chk("fairness_wait", 32'(lowc[i] <= 4), 32'd1);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < 4; i++) lowc[i] = 0;
    step();
    step();
    chk("reset_ready", 32'(bus.req_ready), 32'hF);
    chk("reset_cnt", 32'(bus.conflict_cnt), 32'd0);
    chk("reset_wen0", 32'(bus.wen0), 32'd0);

    rst_n = 1;
    bus.req_valid = 4'b0001;
    set_req(0, 3'd3, 16'hBEEF);
    step();
    chk("single_ready_low", 32'(bus.req_ready), 32'hE);
    chk("single_no_write_yet", 32'(bus.wen0), 32'd0);
    bus.req_valid = '0;
    step();
    chk("single_wen0", 32'(bus.wen0), 32'd1);
    chk("single_waddr0", 32'(bus.waddr0), 32'd3);
    chk("single_wdata0", 32'(bus.wdata0), 32'hBEEF);
    chk("single_wen1", 32'(bus.wen1), 32'd0);
    chk("single_ready_back", 32'(bus.req_ready), 32'hF);

    rst_n = 0;
    step();
    rst_n = 1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 16'h1000 + 16'(i));
    step();
    bus.req_valid = '0;
    step();
    chk("four_c1_p0", {bus.wen0, 13'd0, bus.waddr0, bus.wdata0}, {1'b1, 13'd0, 3'd0, 16'h1000});
    chk("four_c1_p1", {bus.wen1, 13'd0, bus.waddr1, bus.wdata1}, {1'b1, 13'd0, 3'd1, 16'h1001});
    step();
    chk("four_c2_p0", {bus.wen0, 13'd0, bus.waddr0, bus.wdata0}, {1'b1, 13'd0, 3'd2, 16'h1002});
    chk("four_c2_p1", {bus.wen1, 13'd0, bus.waddr1, bus.wdata1}, {1'b1, 13'd0, 3'd3, 16'h1003});
    bus.req_valid = 4'b0011;
    set_req(0, 3'd4, 16'h00AA);
    set_req(1, 3'd6, 16'h00BB);
    step();
    bus.req_valid = '0;
    step();
    chk("rr_back_to_0", {bus.wen0, bus.waddr0}, {1'b1, 3'd4});

    rst_n = 0;
    step();
    rst_n = 1;
    bus.req_valid = 4'b0111;
    set_req(0, 3'd5, 16'd1);
    set_req(1, 3'd5, 16'd2);
    set_req(2, 3'd6, 16'd3);
    step();
    bus.req_valid = '0;
    step();
    chk("conf_p0", {bus.wen0, 13'd0, bus.waddr0, bus.wdata0}, {1'b1, 13'd0, 3'd5, 16'd1});
    chk("conf_p1", {bus.wen1, bus.waddr1}, {1'b1, 3'd6});
    chk("conf_cnt", 32'(bus.conflict_cnt), 32'd1);
    step();
    chk("conf_second", {bus.wen0, 13'd0, bus.waddr0, bus.wdata0}, {1'b1, 13'd0, 3'd5, 16'd2});
    chk("conf_second_wen1", 32'(bus.wen1), 32'd0);

    bus.req_valid = 4'b0111;
    for (int i = 0; i < 3; i++) set_req(i, 3'(i + 1), 16'h2000 + 16'(i));
    step();
    rst_n = 0;
    bus.req_valid = 4'b1111;
    step();
    chk("midrst_ready", 32'(bus.req_ready), 32'hF);
    chk("midrst_cnt", 32'(bus.conflict_cnt), 32'd0);
    rst_n = 1;
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_no_wen", {bus.wen0, bus.wen1}, 2'b00);
    end

    fair = 1;
    for (int i = 0; i < 4; i++) lowc[i] = 0;
    for (int c = 0; c < 60; c++) begin
      bus.req_valid = (c < 40) ? 4'hF : 4'($urandom);
      for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4 * $urandom_range(0, 1)), 16'($urandom));
      step();
    end
    fair = 0;

    for (int c = 0; c < 120; c++) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) set_req(i, 3'($urandom_range(0, 7)), 16'($urandom));
      step();
    end

    bus.req_valid = 4'hF;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 4; i++) set_req(i, 3'd7, 16'($urandom));
      step();
    end
    chk("saturated_cnt", 32'(bus.conflict_cnt), 32'd255);
    bus.req_valid = '0;
    for (int c = 0; c < 6; c++) step();
    chk("saturated_hold", 32'(bus.conflict_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
